// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State enum, opcode constants, datapath mux encodings and an opcode legality helper.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_known(input logic [6:0] op, input bit en_jalr);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: return 1'b1;
      OP_JALR:                                 return en_jalr;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       memReady;

  logic       pcWrite;
  logic       irWrite;
  logic       regWrite;
  logic       memWrite;
  logic       adrSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] resultSrc;
  logic [1:0] inmSrc;
  logic       illegal;

  modport master (
    input  op, funct3, zero, memReady,
    output pcWrite, irWrite, regWrite, memWrite, adrSrc,
           aluSrcA, aluSrcB, aluOp, resultSrc, inmSrc, illegal
  );

  modport slave (
    output op, funct3, zero, memReady,
    input  pcWrite, irWrite, regWrite, memWrite, adrSrc,
           aluSrcA, aluSrcB, aluOp, resultSrc, inmSrc, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// Immediate format select decoded straight from the opcode; unknown opcodes give I format.
module imm_src_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] inmSrc
);

  always_comb begin
    case (op)
      OP_LW, OP_I, OP_JALR: inmSrc = IMM_I;
      OP_SW:                inmSrc = IMM_S;
      OP_BR:                inmSrc = IMM_B;
      OP_JAL:               inmSrc = IMM_J;
      default:              inmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I datapath on a shared instruction/data memory.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE     | ALUOut <= OldPC+imm (branch target), dispatch on opcode
// MEMADR     | ALUOut <= rs1+imm
// MEMREAD    | read data memory at ALUOut
// MEMWB      | rd <= loaded data
// MEMWRITE   | write data memory at ALUOut until ready
// EXECR      | R-type ALU operation
// EXECI      | I-type ALU operation
// ALUWB      | rd <= ALUOut
// BRANCH     | compare rs1/rs2, PC <= target when taken
// JAL        | PC <= target, ALUOut <= OldPC+4
// JALR1      | ALUOut <= rs1+imm
// JALR2      | PC <= ALUOut, ALUOut <= OldPC+4
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit EN_JALR  = 1'b0,
  parameter bit EN_BNE   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t     state, state_nx;
  logic       mem_ok;
  logic       br_take;
  logic       pc_w, ir_w, reg_w, mem_w, adr;
  logic [1:0] src_a, src_b, alu_op, res;
  logic       ill;

  assign mem_ok = MEM_WAIT ? bus.memReady : 1'b1;

  // Without BNE support funct3 is ignored and every branch is treated as beq.
  assign br_take = EN_BNE ? ((bus.funct3 == 3'b000) ? bus.zero :
                             (bus.funct3 == 3'b001) ? ~bus.zero : 1'b0)
                          : bus.zero;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    if (mem_ok) state_nx = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXECR;
          OP_I:         state_nx = S_EXECI;
          OP_BR:        state_nx = S_BRANCH;
          OP_JAL:       state_nx = S_JAL;
          OP_JALR:      state_nx = EN_JALR ? S_JALR1 : S_FETCH;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nx = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ok) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_nx = S_FETCH;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_JALR1:    state_nx = S_JALR2;
      S_JALR2:    state_nx = S_ALUWB;
      default:    state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    pc_w   = 1'b0;
    ir_w   = 1'b0;
    reg_w  = 1'b0;
    mem_w  = 1'b0;
    adr    = 1'b0;
    src_a  = SRCA_PC;
    src_b  = SRCB_RS2;
    alu_op = ALUOP_ADD;
    res    = RES_ALUOUT;
    ill    = 1'b0;
    case (state)
      S_FETCH: begin
        src_b = SRCB_FOUR;
        res   = RES_ALURESULT;
        ir_w  = mem_ok;
        pc_w  = mem_ok;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        ill   = ~op_known(bus.op, EN_JALR);
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: adr = 1'b1;
      S_MEMWB: begin
        res   = RES_DATA;
        reg_w = 1'b1;
      end
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RS1;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a  = SRCA_RS1;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        src_a  = SRCA_RS1;
        alu_op = ALUOP_SUB;
        pc_w   = br_take;
      end
      S_JAL, S_JALR2: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_FOUR;
        pc_w  = 1'b1;
      end
      S_JALR1: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

  // Write enables are held off during reset so an interrupted access cannot commit.
  assign bus.pcWrite   = pc_w  & ~reset;
  assign bus.irWrite   = ir_w  & ~reset;
  assign bus.regWrite  = reg_w & ~reset;
  assign bus.memWrite  = mem_w & ~reset;
  assign bus.adrSrc    = adr;
  assign bus.aluSrcA   = src_a;
  assign bus.aluSrcB   = src_b;
  assign bus.aluOp     = alu_op;
  assign bus.resultSrc = res;
  assign bus.illegal   = ill;

  imm_src_dec u_imm_src_dec (
    .op     (bus.op),
    .inmSrc (bus.inmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a plain instance and one with wait/JALR/BNE enabled,
// checked cycle by cycle against expected control vectors queued as stimulus is scheduled.
module tb_multicycle_ctrl;

  typedef enum int {FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
                    ALUWB, BRANCH, JAL, JALR1, JALR2} tstate_t;

  typedef struct {
    logic [15:0] exp;
    logic        rdy;
    logic        rst;
    string       tag;
  } step_t;

  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_I    = 7'b0010011;
  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_BAD  = 7'b1111111;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sel   = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_zero;

  step_t sbq[$];

  multicycle_ctrl_if if0 ();
  multicycle_ctrl_if if1 ();

  multicycle_ctrl dut0 (.clk(clk), .reset(reset), .bus(if0.master));

  multicycle_ctrl #(.MEM_WAIT(1'b1), .EN_JALR(1'b1), .EN_BNE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.master));

  logic [15:0] obs0, obs1;
  assign obs0 = {if0.pcWrite, if0.irWrite, if0.regWrite, if0.memWrite, if0.adrSrc,
                 if0.aluSrcA, if0.aluSrcB, if0.aluOp, if0.resultSrc, if0.inmSrc, if0.illegal};
  assign obs1 = {if1.pcWrite, if1.irWrite, if1.regWrite, if1.memWrite, if1.adrSrc,
                 if1.aluSrcA, if1.aluSrcB, if1.aluOp, if1.resultSrc, if1.inmSrc, if1.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for one cycle, straight from the state table.
  function automatic logic [15:0] exp_vec(tstate_t st, logic rdy, logic rst, bit ext,
                                          logic [6:0] op, logic [2:0] f3, logic z);
    logic pcw, irw, rgw, mmw, adr, ill, rdy_eff;
    logic [1:0] a, b, alu, res, imm;
    pcw = 0; irw = 0; rgw = 0; mmw = 0; adr = 0; ill = 0;
    a = 2'b00; b = 2'b00; alu = 2'b00; res = 2'b00;
    rdy_eff = ext ? rdy : 1'b1;
    case (st)
      FETCH:    begin b = 2'b10; res = 2'b10; irw = rdy_eff; pcw = rdy_eff; end
      DECODE:   begin
        a = 2'b01; b = 2'b01;
        ill = !(op == T_LW || op == T_SW || op == T_R || op == T_I || op == T_BR ||
                op == T_JAL || (ext && op == T_JALR));
      end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  adr = 1;
      MEMWB:    begin res = 2'b01; rgw = 1; end
      MEMWRITE: begin adr = 1; mmw = 1; end
      EXECR:    begin a = 2'b10; alu = 2'b10; end
      EXECI:    begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      ALUWB:    rgw = 1;
      BRANCH:   begin
        a = 2'b10; alu = 2'b01;
        if (!ext)              pcw = z;
        else if (f3 == 3'b000) pcw = z;
        else if (f3 == 3'b001) pcw = !z;
        else                   pcw = 0;
      end
      JAL, JALR2: begin a = 2'b01; b = 2'b10; pcw = 1; end
      JALR1:    begin a = 2'b10; b = 2'b01; end
      default:  ;
    endcase
    if (op == T_SW)       imm = 2'b01;
    else if (op == T_BR)  imm = 2'b10;
    else if (op == T_JAL) imm = 2'b11;
    else                  imm = 2'b00;
    if (rst) begin pcw = 0; irw = 0; rgw = 0; mmw = 0; end
    return {pcw, irw, rgw, mmw, adr, a, b, alu, res, imm, ill};
  endfunction

  task automatic push(input tstate_t st, input logic rdy, input logic rst, input string name);
    step_t s;
    s.exp = exp_vec(st, rdy, rst, (sel != 0), cur_op, cur_f3, cur_zero);
    s.rdy = rdy;
    s.rst = rst;
    s.tag = $sformatf("%s/%s", name, st.name());
    sbq.push_back(s);
  endtask

  task automatic drive(input logic rdy);
    if0.op = cur_op; if0.funct3 = cur_f3; if0.zero = cur_zero; if0.memReady = rdy;
    if1.op = cur_op; if1.funct3 = cur_f3; if1.zero = cur_zero; if1.memReady = rdy;
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      step_t s;
      logic [15:0] o;
      s = sbq.pop_front();
      reset = s.rst;
      drive(s.rdy);
      @(negedge clk);
      o = (sel != 0) ? obs1 : obs0;
      n_cmp++;
      assert (o === s.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %b required %b", s.tag, o, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n, input string name);
    logic [3:0] en;
    reset = 1'b1;
    drive(1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = (sel != 0) ? obs1[15:12] : obs0[15:12];
      n_cmp++;
      assert (en === 4'b0000) else begin
        n_bad++;
        $error("FAIL %s enables c%0d: observed %b required 0000", name, i, en);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic set_instr(input int s, input logic [6:0] op, input logic [2:0] f3, input logic z);
    sel = s; cur_op = op; cur_f3 = f3; cur_zero = z;
  endtask

  initial begin
    reset = 1'b1;
    set_instr(0, T_R, 3'b000, 1'b0);
    drive(1'b1);
    @(posedge clk);
    #1;

    // R-type, no memory wait
    do_reset(2, "rst0");
    push(FETCH, 1, 0, "rtype"); push(DECODE, 1, 0, "rtype"); push(EXECR, 1, 0, "rtype");
    push(ALUWB, 1, 0, "rtype"); push(FETCH, 1, 0, "rtype");
    drain();

    // Load with two not-ready cycles in MEMREAD; memReady low in DECODE must be ignored
    set_instr(1, T_LW, 3'b010, 1'b0);
    do_reset(1, "rst1");
    push(FETCH, 1, 0, "lw"); push(DECODE, 0, 0, "lw"); push(MEMADR, 0, 0, "lw");
    push(MEMREAD, 0, 0, "lw"); push(MEMREAD, 0, 0, "lw"); push(MEMREAD, 1, 0, "lw");
    push(MEMWB, 0, 0, "lw"); push(FETCH, 1, 0, "lw");
    drain();

    // Store without wait
    set_instr(0, T_SW, 3'b010, 1'b0);
    do_reset(1, "rst2");
    push(FETCH, 0, 0, "sw"); push(DECODE, 0, 0, "sw"); push(MEMADR, 0, 0, "sw");
    push(MEMWRITE, 0, 0, "sw"); push(FETCH, 1, 0, "sw");
    drain();

    // beq taken on the plain instance
    set_instr(0, T_BR, 3'b000, 1'b1);
    do_reset(1, "rst3");
    push(FETCH, 1, 0, "beq"); push(DECODE, 1, 0, "beq"); push(BRANCH, 1, 0, "beq");
    push(FETCH, 1, 0, "beq");
    drain();

    // funct3=001 on the plain instance still behaves as beq
    set_instr(0, T_BR, 3'b001, 1'b1);
    do_reset(1, "rst4");
    push(FETCH, 1, 0, "nobne"); push(DECODE, 1, 0, "nobne"); push(BRANCH, 1, 0, "nobne");
    drain();

    // bne with zero=1 (not taken) and zero=0 (taken), then reserved funct3
    set_instr(1, T_BR, 3'b001, 1'b1);
    do_reset(1, "rst5");
    push(FETCH, 1, 0, "bne_z1"); push(DECODE, 1, 0, "bne_z1"); push(BRANCH, 1, 0, "bne_z1");
    drain();
    set_instr(1, T_BR, 3'b001, 1'b0);
    do_reset(1, "rst6");
    push(FETCH, 1, 0, "bne_z0"); push(DECODE, 1, 0, "bne_z0"); push(BRANCH, 1, 0, "bne_z0");
    drain();
    set_instr(1, T_BR, 3'b010, 1'b1);
    do_reset(1, "rst7");
    push(FETCH, 1, 0, "br_f3"); push(DECODE, 1, 0, "br_f3"); push(BRANCH, 1, 0, "br_f3");
    push(FETCH, 1, 0, "br_f3");
    drain();

    // jal
    set_instr(0, T_JAL, 3'b000, 1'b0);
    do_reset(1, "rst8");
    push(FETCH, 1, 0, "jal"); push(DECODE, 1, 0, "jal"); push(JAL, 1, 0, "jal");
    push(ALUWB, 1, 0, "jal"); push(FETCH, 1, 0, "jal");
    drain();

    // jalr enabled, then disabled (illegal)
    set_instr(1, T_JALR, 3'b000, 1'b0);
    do_reset(1, "rst9");
    push(FETCH, 1, 0, "jalr"); push(DECODE, 1, 0, "jalr"); push(JALR1, 1, 0, "jalr");
    push(JALR2, 1, 0, "jalr"); push(ALUWB, 1, 0, "jalr"); push(FETCH, 1, 0, "jalr");
    drain();
    set_instr(0, T_JALR, 3'b000, 1'b0);
    do_reset(1, "rst10");
    push(FETCH, 1, 0, "nojalr"); push(DECODE, 1, 0, "nojalr"); push(FETCH, 1, 0, "nojalr");
    drain();

    // I-type and an unknown opcode on the extended instance
    set_instr(1, T_I, 3'b000, 1'b0);
    do_reset(1, "rst11");
    push(FETCH, 1, 0, "itype"); push(DECODE, 1, 0, "itype"); push(EXECI, 1, 0, "itype");
    push(ALUWB, 1, 0, "itype"); push(FETCH, 1, 0, "itype");
    drain();
    set_instr(1, T_BAD, 3'b000, 1'b0);
    do_reset(1, "rst12");
    push(FETCH, 1, 0, "badop"); push(DECODE, 1, 0, "badop"); push(FETCH, 1, 0, "badop");
    drain();

    // Reset raised while a store is stalled in MEMWRITE
    set_instr(1, T_SW, 3'b010, 1'b0);
    do_reset(1, "rst13");
    push(FETCH, 1, 0, "midst"); push(DECODE, 0, 0, "midst"); push(MEMADR, 0, 0, "midst");
    push(MEMWRITE, 0, 0, "midst"); push(MEMWRITE, 0, 0, "midst");
    push(MEMWRITE, 0, 1, "midst_rst"); push(FETCH, 0, 0, "midst_after");
    push(FETCH, 1, 0, "midst_after");
    drain();

    // Fetch stall for three cycles, then an R-type completes
    set_instr(1, T_R, 3'b000, 1'b0);
    do_reset(1, "rst14");
    push(FETCH, 0, 0, "fstall"); push(FETCH, 0, 0, "fstall"); push(FETCH, 0, 0, "fstall");
    push(FETCH, 1, 0, "fstall"); push(DECODE, 0, 0, "fstall"); push(EXECR, 0, 0, "fstall");
    push(ALUWB, 0, 0, "fstall"); push(FETCH, 1, 0, "fstall");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
